hh_step_sequencer: RTL and testbench
====================================

// Module: hh_step_sequencer
// PURPOSE
//  Per-step controller for the Hodgkin-Huxley neuron datapath. Sequences one
//  integration step: gate-variable update handshake, then Na/K/leak channel
//  currents on a single shared Q8.8 multiplier, then the membrane update
//  V += DT_OVER_C*(i_ext - I_NA - I_K - I_L). Sits between the step tick
//  source and the gate updaters; owns the membrane-potential state register.
// PARAMETERS
//  G_NA        16'h7800  Na conductance, Q8.8 signed (120.0)
//  G_K         16'h2400  K conductance (36.0)
//  G_L         16'h004D  leak conductance (~0.3)
//  E_NA        16'h3200  Na reversal (50.0)
//  E_K         16'hB300  K reversal (-77.0)
//  E_L         16'hC99A  leak reversal (~-54.4)
//  V_REST      16'hBF00  reset membrane potential (-65.0)
//  DT_OVER_C   16'h0010  dt/Cm (0.0625)
//  GATE_TIMEOUT 64       max cycles waiting for gate_done
// PORTS
//  clk        in   1   clock
//  rst        in   1   asynchronous, active-high reset
//  step_req   in   1   request one integration step
//  step_ready out  1   high in IDLE only; step accepted when step_req&step_ready
//  i_ext      in   16  external current, Q8.8, sampled at step accept
//  gate_start out  1   1-cycle pulse: gate updaters compute m,h,n from v_out
//  gate_done  in   1   gate updaters finished; m,h,n valid this cycle
//  m, h, n    in   16  gate variables, Q8.8 (0x0000..0x0100)
//  v_out      out  16  membrane potential register
//  i_na,i_k,i_l out 16 last computed channel currents
//  v_valid    out  1   1-cycle pulse: v_out/currents updated
//  err        out  1   1-cycle pulse: gate timeout
// BEHAVIOUR
//  Reset: state=IDLE, v_out=V_REST, i_na=i_k=i_l=0, all pulses 0, step_ready=1.
//  FSM: IDLE->GATE on accept; GATE->NA1 when gate_done (m,h,n latched);
//   NA1 (G_NA*m) -> NA2 (*h) -> NA3 (*(v-E_NA), ->i_na) -> K1 (G_K*n)
//   -> K2 (*(v-E_K), ->i_k) -> L1 (G_L*(v-E_L), ->i_l) -> SUM -> VUPD -> DONE -> IDLE.
//  One multiply per state, result registered at state end.
//  gate_start asserted only in the first GATE cycle.
//  v_valid high in DONE = 9th cycle after gate_done sampled (8 w/o leak).
//  Multiply: 16x16 signed ->32b, take [23:8], saturate to 0x7FFF/0x8000.
//  Add/sub (v-E, SUM, v+delta): 17b intermediate, saturate to 16b.
//  SUM = i_ext - i_na - i_k - i_l, saturated after each subtraction.
//  step_req while not IDLE: ignored, no queueing.
//  gate_done outside GATE: ignored.
//  Timeout: GATE_TIMEOUT cycles in GATE without gate_done -> err pulse,
//   ->IDLE, v_out and currents unchanged, no v_valid.
//  Reset mid-step: immediate abort to reset values.
// CONFIGURATION
//  HH_LEAK_EN defined: L1 state present, i_l computed.
//  HH_LEAK_EN undefined: L1 skipped, i_l tied 0, step one cycle shorter.
// TESTING
//  Reset, leak off, i_ext=0, m=h=n=0 -> v_out=0xBF00, i_na=i_k=0.
//  Leak off, i_ext=0x0A00, gates 0 -> v_out=0xBFA0; v_valid 8 cycles after gate_done.
//  m=h=0x0100, n=0, i_ext=0, leak off -> i_na=0x8000 (sat), v_out=0xC6FF.
//  gate_done never asserted -> err pulse after 64 GATE cycles; v_out stays 0xBF00.
//  step_req held during step -> step_ready=0, exactly one v_valid per accept.
//  rst mid-NA2 -> v_out=0xBF00, step_ready=1 next cycle, no v_valid.

Source files
------------

// File: rtl/hh_step_sequencer.sv
// Hodgkin-Huxley per-step controller: gate handshake, channel currents, V update.
// Optional leak channel enabled by defining HH_LEAK_EN.
module hh_step_sequencer #(
  parameter logic [15:0] G_NA      = 16'h7800,
  parameter logic [15:0] G_K       = 16'h2400,
  parameter logic [15:0] G_L       = 16'h004D,
  parameter logic [15:0] E_NA      = 16'h3200,
  parameter logic [15:0] E_K       = 16'hB300,
  parameter logic [15:0] E_L       = 16'hC99A,
  parameter logic [15:0] V_REST    = 16'hBF00,
  parameter logic [15:0] DT_OVER_C = 16'h0010,
  parameter int          GATE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_req,
  output logic        step_ready,
  input  logic [15:0] i_ext,
  output logic        gate_start,
  input  logic        gate_done,
  input  logic [15:0] m,
  input  logic [15:0] h,
  input  logic [15:0] n,
  output logic [15:0] v_out,
  output logic [15:0] i_na,
  output logic [15:0] i_k,
  output logic [15:0] i_l,
  output logic        v_valid,
  output logic        err
);

  localparam int TW = $clog2(GATE_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(GATE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_GATE, S_NA1, S_NA2, S_NA3,
    S_K1, S_K2, S_L1, S_SUM, S_VUPD, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TW-1:0] r_tmo;
  logic          r_err;
  logic [15:0]   r_v;
  logic [15:0]   r_ina;
  logic [15:0]   r_ik;
  logic [15:0]   r_ext;
  logic [15:0]   r_m;
  logic [15:0]   r_h;
  logic [15:0]   r_n;
  logic [15:0]   r_prod;
  logic [15:0]   r_acc;
  logic [15:0]   w_il;
  logic [15:0]   w_ma;
  logic [15:0]   w_mb;
  logic [15:0]   w_mres;
  logic          w_tmo;

  // Q8.8 product: keep [23:8] of the 32b result, clamp on overflow
  function automatic logic [15:0] f_mul(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    logic signed [31:0] p;
    logic signed [31:0] q;
    p = 32'(a) * 32'(b);
    q = p >>> 8;
    if (q[31:15] == {17{q[31]}})
      f_mul = q[15:0];
    else
      f_mul = q[31] ? 16'h8000 : 16'h7FFF;
  endfunction

  function automatic logic [15:0] f_sat(input logic signed [16:0] s);
    if (s[16] != s[15])
      f_sat = s[16] ? 16'h8000 : 16'h7FFF;
    else
      f_sat = s[15:0];
  endfunction

  function automatic logic [15:0] f_add(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    f_add = f_sat(17'(a) + 17'(b));
  endfunction

  function automatic logic [15:0] f_sub(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    f_sub = f_sat(17'(a) - 17'(b));
  endfunction

`ifdef HH_LEAK_EN
  logic [15:0] r_il;
  assign w_il = r_il;
`else
  assign w_il = '0;
`endif

  assign w_tmo = (r_state == S_GATE) && !gate_done && (r_tmo == TMO_LAST);

  // Operand select for the single shared multiplier
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      S_NA1:   begin w_ma = G_NA;      w_mb = r_m; end
      S_NA2:   begin w_ma = r_prod;    w_mb = r_h; end
      S_NA3:   begin w_ma = r_prod;    w_mb = f_sub(r_v, E_NA); end
      S_K1:    begin w_ma = G_K;       w_mb = r_n; end
      S_K2:    begin w_ma = r_prod;    w_mb = f_sub(r_v, E_K); end
      S_L1:    begin w_ma = G_L;       w_mb = f_sub(r_v, E_L); end
      S_VUPD:  begin w_ma = DT_OVER_C; w_mb = r_acc; end
      default: ;
    endcase
  end

  assign w_mres = f_mul(w_ma, w_mb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (step_req) w_next = S_GATE;
      S_GATE: begin
        if (gate_done)
          w_next = S_NA1;
        else if (r_tmo == TMO_LAST)
          w_next = S_IDLE;
      end
      S_NA1:  w_next = S_NA2;
      S_NA2:  w_next = S_NA3;
      S_NA3:  w_next = S_K1;
      S_K1:   w_next = S_K2;
`ifdef HH_LEAK_EN
      S_K2:   w_next = S_L1;
`else
      S_K2:   w_next = S_SUM;
`endif
      S_L1:   w_next = S_SUM;
      S_SUM:  w_next = S_VUPD;
      S_VUPD: w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    step_ready = (r_state == S_IDLE);
    gate_start = (r_state == S_GATE) && (r_tmo == '0);
    v_valid    = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo  <= '0;
      r_err  <= 1'b0;
      r_v    <= V_REST;
      r_ina  <= '0;
      r_ik   <= '0;
      r_ext  <= '0;
      r_m    <= '0;
      r_h    <= '0;
      r_n    <= '0;
      r_prod <= '0;
      r_acc  <= '0;
`ifdef HH_LEAK_EN
      r_il   <= '0;
`endif
    end else begin
      r_err <= w_tmo;
      r_tmo <= (r_state == S_GATE) ? r_tmo + 1'b1 : '0;
      case (r_state)
        S_IDLE: if (step_req) r_ext <= i_ext;
        S_GATE: begin
          if (gate_done) begin
            r_m <= m;
            r_h <= h;
            r_n <= n;
          end
        end
        S_NA1, S_NA2, S_K1: r_prod <= w_mres;
        S_NA3: r_ina <= w_mres;
        S_K2:  r_ik  <= w_mres;
`ifdef HH_LEAK_EN
        S_L1:  r_il  <= w_mres;
`endif
        S_SUM: r_acc <= f_sub(f_sub(f_sub(r_ext, r_ina), r_ik), w_il);
        S_VUPD: r_v <= f_add(r_v, w_mres);
        default: ;
      endcase
    end
  end

  assign v_out = r_v;
  assign i_na  = r_ina;
  assign i_k   = r_ik;
  assign i_l   = w_il;
  assign err   = r_err;

endmodule

// File: tb/tb_hh_step_sequencer.sv
// Directed bench for hh_step_sequencer (default build, leak channel off).
module tb_hh_step_sequencer;

`ifdef HH_LEAK_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic        clk;
  logic        rst;
  logic        step_req;
  logic        step_ready;
  logic [15:0] i_ext;
  logic        gate_start;
  logic        gate_done;
  logic [15:0] m;
  logic [15:0] h;
  logic [15:0] n;
  logic [15:0] v_out;
  logic [15:0] i_na;
  logic [15:0] i_k;
  logic [15:0] i_l;
  logic        v_valid;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  hh_step_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .step_req   (step_req),
    .step_ready (step_ready),
    .i_ext      (i_ext),
    .gate_start (gate_start),
    .gate_done  (gate_done),
    .m          (m),
    .h          (h),
    .n          (n),
    .v_out      (v_out),
    .i_na       (i_na),
    .i_k        (i_k),
    .i_l        (i_l),
    .v_valid    (v_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_step(input logic [15:0] ext, input logic [15:0] gm,
                         input logic [15:0] gh, input logic [15:0] gn,
                         output int lat, output logic gs);
    @(negedge clk);
    step_req = 1'b1;
    i_ext    = ext;
    @(negedge clk);
    step_req  = 1'b0;
    gs        = gate_start;
    gate_done = 1'b1;
    m = gm;
    h = gh;
    n = gn;
    @(negedge clk);
    gate_done = 1'b0;
    lat = 1;
    while (!v_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    logic gs;
    int   g;
    int   acc;
    int   val;
    logic seen;

    rst = 1'b1;
    step_req = 1'b0;
    i_ext = '0;
    gate_done = 1'b0;
    m = '0;
    h = '0;
    n = '0;
    @(negedge clk);
    chk("rst_v", v_out, 16'hBF00);
    chk("rst_ready", step_ready, 1'b1);
    chk("rst_ina", i_na, 16'h0000);
    chk("rst_ik", i_k, 16'h0000);
    chk("rst_il", i_l, 16'h0000);
    chk("rst_pulses", {gate_start, v_valid, err}, 3'b000);
    rst = 1'b0;

    do_step(16'h0000, 16'h0, 16'h0, 16'h0, lat, gs);
    chk("zero_gs", gs, 1'b1);
    chk("zero_lat", lat, LAT);
    chk("zero_v", v_out, 16'hBF00);
    chk("zero_ina", i_na, 16'h0000);
    chk("zero_ik", i_k, 16'h0000);

    do_step(16'h0A00, 16'h0, 16'h0, 16'h0, lat, gs);
    chk("ext_lat", lat, LAT);
    chk("ext_v", v_out, 16'hBFA0);
    @(negedge clk);
    chk("ext_pulse1", v_valid, 1'b0);

    // abort in NA2 must restore reset values
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req  = 1'b0;
    gate_done = 1'b1;
    @(negedge clk);
    gate_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_v", v_out, 16'hBF00);
    chk("abort_ready", step_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (v_valid) seen = 1'b1;
    end
    chk("abort_novalid", seen, 1'b0);
    chk("abort_ready2", step_ready, 1'b1);

    do_step(16'h0000, 16'h0100, 16'h0100, 16'h0, lat, gs);
    chk("na_lat", lat, LAT);
    chk("na_ina", i_na, 16'h8000);
    chk("na_v", v_out, 16'hC6FF);

    do_reset();
    do_step(16'h0000, 16'h0, 16'h0, 16'h0100, lat, gs);
    chk("k_lat", lat, LAT);
    chk("k_ik", i_k, 16'h7FFF);
    chk("k_ina", i_na, 16'h0000);
    chk("k_v", v_out, 16'hB700);

    // gate timeout: no gate_done at all
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    chk("tmo_gs1", gate_start, 1'b1);
    g = 1;
    @(negedge clk);
    chk("tmo_gs2", gate_start, 1'b0);
    g = 2;
    seen = 1'b0;
    while (!err && g < 200) begin
      @(negedge clk);
      if (v_valid) seen = 1'b1;
      if (!step_ready) g++;
    end
    chk("tmo_err", err, 1'b1);
    chk("tmo_cycles", g, 64);
    chk("tmo_novalid", seen, 1'b0);
    @(negedge clk);
    chk("tmo_errpulse", err, 1'b0);
    chk("tmo_v", v_out, 16'hB700);
    chk("tmo_ik", i_k, 16'h7FFF);

    gate_done = 1'b1;
    @(negedge clk);
    gate_done = 1'b0;
    chk("idle_gd_ready", step_ready, 1'b1);
    chk("idle_gd_valid", v_valid, 1'b0);

    // held request: one v_valid per accept, ten-cycle round trip
    step_req  = 1'b1;
    gate_done = 1'b1;
    i_ext = '0;
    m = '0;
    h = '0;
    n = '0;
    acc = 0;
    val = 0;
    for (int t = 0; t < 10 * 4; t++) begin
      if (step_ready) acc++;
      if (v_valid) val++;
      @(negedge clk);
    end
    step_req  = 1'b0;
    gate_done = 1'b0;
    chk("held_accepts", acc, 4);
    chk("held_valids", val, 4);
    chk("held_v", v_out, 16'hB700);
    chk("held_ik", i_k, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
